// File: rtl/ysyx_24090003_regfile_sb_if.sv
// Register-file / scoreboard bus: two read ports, issue claim, writeback and flush.
// master = pipeline side, slave = register file.
interface ysyx_24090003_regfile_sb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
);
  localparam int unsigned AW = $clog2(NREG);

  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;

  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            iss_ready;

  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            flush;
  logic            sb_err;

  modport master (
    output rs1_addr, rs2_addr, iss_valid, iss_rd, wb_valid, wb_rd, wb_data, flush,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, iss_ready, sb_err
  );

  modport slave (
    input  rs1_addr, rs2_addr, iss_valid, iss_rd, wb_valid, wb_rd, wb_data, flush,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, iss_ready, sb_err
  );
endinterface

// File: rtl/ysyx_24090003_regfile_sb.sv
// General-purpose register file with a per-register busy scoreboard.
// x0 reads zero, is never written and is never busy.
module ysyx_24090003_regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned BYPASS = 1
) (
  input  logic                            cpu_clk,
  input  logic                            cpu_rst_n,
  ysyx_24090003_regfile_sb_if.slave       rf_bus
);
  localparam int unsigned AW        = $clog2(NREG);
  localparam bit          UseBypass = (BYPASS != 0);

  logic [XLEN-1:0] gpr_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            sb_err_q, sb_err_d;
  logic            flush_q;

  logic            wb_en;
  logic            claim;
  logic            fwd1, fwd2;
  logic            wb_hit1, wb_hit2;

  // Writeback and claim qualification; a claim on x0 is accepted but marks nothing.
  always_comb begin
    wb_en = rf_bus.wb_valid & (rf_bus.wb_rd != '0);
    rf_bus.iss_ready = ~rf_bus.flush &
                       ((rf_bus.iss_rd == '0) | ~busy_q[rf_bus.iss_rd] |
                        (rf_bus.wb_valid & (rf_bus.wb_rd == rf_bus.iss_rd)));
    claim = rf_bus.iss_valid & rf_bus.iss_ready & (rf_bus.iss_rd != '0);
  end

  // Scoreboard next state: clear on writeback, then set on claim so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_bus.flush) begin
      busy_d = '0;
    end else begin
      if (rf_bus.wb_valid) busy_d[rf_bus.wb_rd] = 1'b0;
      if (claim)           busy_d[rf_bus.iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Sticky error on a writeback nobody claimed; writebacks right after a flush are expected.
  always_comb begin
    sb_err_d = sb_err_q | (wb_en & ~busy_q[rf_bus.wb_rd] & ~flush_q);
  end

  // Register array; x0 stays at its reset value forever.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      for (int i = 0; i < int'(NREG); i++) gpr_q[i] <= '0;
    end else if (wb_en) begin
      gpr_q[rf_bus.wb_rd] <= rf_bus.wb_data;
    end
  end

  // Scoreboard, error flag and flush history.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
      flush_q  <= rf_bus.flush;
    end
  end

  // Read ports; forwarding is held off during reset so outputs show the cleared state.
  always_comb begin
    wb_hit1 = UseBypass & rf_bus.wb_valid & (rf_bus.wb_rd == rf_bus.rs1_addr);
    wb_hit2 = UseBypass & rf_bus.wb_valid & (rf_bus.wb_rd == rf_bus.rs2_addr);
    fwd1    = wb_hit1 & wb_en & cpu_rst_n;
    fwd2    = wb_hit2 & wb_en & cpu_rst_n;

    rf_bus.rs1_data = fwd1 ? rf_bus.wb_data : gpr_q[rf_bus.rs1_addr];
    rf_bus.rs2_data = fwd2 ? rf_bus.wb_data : gpr_q[rf_bus.rs2_addr];
    rf_bus.rs1_busy = busy_q[rf_bus.rs1_addr] & ~wb_hit1;
    rf_bus.rs2_busy = busy_q[rf_bus.rs2_addr] & ~wb_hit2;
    rf_bus.sb_err   = sb_err_q;
  end
endmodule

// File: tb/tb_ysyx_24090003_regfile_sb.sv
// Directed bench: one forwarding DUT and one non-forwarding DUT share the same stimulus.
module tb_ysyx_24090003_regfile_sb;
  logic cpu_clk;
  logic cpu_rst_n;
  int   total;
  int   bad;

  ysyx_24090003_regfile_sb_if #(.XLEN(32), .NREG(32)) bus ();
  ysyx_24090003_regfile_sb_if #(.XLEN(32), .NREG(32)) bus_nb ();

  assign bus_nb.rs1_addr  = bus.rs1_addr;
  assign bus_nb.rs2_addr  = bus.rs2_addr;
  assign bus_nb.iss_valid = bus.iss_valid;
  assign bus_nb.iss_rd    = bus.iss_rd;
  assign bus_nb.wb_valid  = bus.wb_valid;
  assign bus_nb.wb_rd     = bus.wb_rd;
  assign bus_nb.wb_data   = bus.wb_data;
  assign bus_nb.flush     = bus.flush;

  ysyx_24090003_regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst_n (cpu_rst_n),
    .rf_bus    (bus)
  );

  ysyx_24090003_regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_nb (
    .cpu_clk   (cpu_clk),
    .cpu_rst_n (cpu_rst_n),
    .rf_bus    (bus_nb)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.flush     = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later still.
  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cpu_rst_n = 1'b0;
    idle();
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd0;
    #2;
    chk("rst_rs1_data", bus.rs1_data, 0);
    chk("rst_rs1_busy", bus.rs1_busy, 0);
    chk("rst_sb_err", bus.sb_err, 0);
    chk("rst_iss_ready", bus.iss_ready, 1);
    #10 cpu_rst_n = 1'b1;
    step();

    // Reads after reset
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd0;
    #1;
    chk("post_rst_rs1_data", bus.rs1_data, 0);
    chk("post_rst_rs2_data", bus.rs2_data, 0);
    chk("post_rst_rs1_busy", bus.rs1_busy, 0);
    chk("post_rst_rs2_busy", bus.rs2_busy, 0);
    chk("post_rst_sb_err", bus.sb_err, 0);

    // Claim x7, then writeback next cycle
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd7;
    bus.rs1_addr  = 5'd7;
    #1;
    chk("claim7_ready", bus.iss_ready, 1);
    step();
    idle();
    #1;
    chk("x7_busy", bus.rs1_busy, 1);
    chk("x7_busy_nb", bus_nb.rs1_busy, 1);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd7;
    bus.wb_data  = 32'hDEAD_BEEF;
    #1;
    chk("byp_data", bus.rs1_data, 32'hDEAD_BEEF);
    chk("byp_busy", bus.rs1_busy, 0);
    chk("nb_busy_wb_cycle", bus_nb.rs1_busy, 1);
    chk("nb_data_wb_cycle", bus_nb.rs1_data, 0);
    step();
    idle();
    bus.rs2_addr = 5'd7;
    #1;
    chk("nb_data_after", bus_nb.rs1_data, 32'hDEAD_BEEF);
    chk("nb_busy_after", bus_nb.rs1_busy, 0);
    chk("byp_data_after", bus.rs1_data, 32'hDEAD_BEEF);
    chk("same_addr_data", bus.rs2_data, 32'hDEAD_BEEF);
    chk("same_addr_busy", bus.rs2_busy, 0);
    chk("x7_no_err", bus.sb_err, 0);

    // x0 write and claim
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 5'd0;
    bus.wb_data   = 32'h1234;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd0;
    bus.rs1_addr  = 5'd0;
    #1;
    chk("x0_ready", bus.iss_ready, 1);
    chk("x0_no_fwd", bus.rs1_data, 0);
    step();
    idle();
    #1;
    chk("x0_data", bus.rs1_data, 0);
    chk("x0_busy", bus.rs1_busy, 0);
    chk("x0_no_err", bus.sb_err, 0);

    // WAW stall on x3
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd3;
    bus.rs1_addr  = 5'd3;
    step();
    #1;
    chk("waw_stall", bus.iss_ready, 0);
    chk("x3_busy", bus.rs1_busy, 1);
    step();
    chk("waw_stall_held", bus.iss_ready, 0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd3;
    bus.wb_data  = 32'hA5;
    #1;
    chk("waw_release", bus.iss_ready, 1);
    step();
    idle();
    #1;
    chk("x3_still_busy", bus.rs1_busy, 1);
    chk("x3_data", bus.rs1_data, 32'hA5);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd3;
    bus.wb_data  = 32'hA6;
    step();
    idle();
    #1;
    chk("x3_cleared", bus.rs1_busy, 0);
    chk("x3_no_err", bus.sb_err, 0);

    // Flush with pending x4/x9 and a simultaneous writeback to x4
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd4;
    step();
    bus.iss_rd    = 5'd9;
    step();
    bus.iss_rd   = 5'd10;
    bus.flush    = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd4;
    bus.wb_data  = 32'h55;
    #1;
    chk("flush_no_ready", bus.iss_ready, 0);
    step();
    idle();
    bus.rs1_addr = 5'd4;
    bus.rs2_addr = 5'd9;
    #1;
    chk("flush_x4_busy", bus.rs1_busy, 0);
    chk("flush_x9_busy", bus.rs2_busy, 0);
    chk("flush_x4_data", bus.rs1_data, 32'h55);
    chk("flush_no_err", bus.sb_err, 0);
    bus.rs2_addr = 5'd10;
    #1;
    chk("flush_x10_not_claimed", bus.rs2_busy, 0);
    bus.rs2_addr = 5'd9;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd9;
    bus.wb_data  = 32'h99;
    step();
    idle();
    #1;
    chk("late_wb_no_err", bus.sb_err, 0);
    chk("late_wb_data", bus.rs2_data, 32'h99);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd9;
    bus.wb_data  = 32'h9A;
    step();
    idle();
    #1;
    chk("stray_wb_err", bus.sb_err, 1);
    step();
    chk("err_sticky", bus.sb_err, 1);

    // Async reset while x2 is busy
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd2;
    bus.rs1_addr  = 5'd2;
    step();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd2;
    bus.wb_data  = 32'h22;
    step();
    idle();
    #1;
    chk("x2_busy_set_wins", bus.rs1_busy, 1);
    chk("x2_data", bus.rs1_data, 32'h22);
    #2 cpu_rst_n = 1'b0;
    #1;
    chk("async_busy", bus.rs1_busy, 0);
    chk("async_err", bus.sb_err, 0);
    chk("async_x2", bus.rs1_data, 0);
    chk("async_ready", bus.iss_ready, 1);
    #1 cpu_rst_n = 1'b1;
    step();
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd2;
    #1;
    chk("clean_ready", bus.iss_ready, 1);
    step();
    idle();
    #1;
    chk("clean_claim", bus.rs1_busy, 1);
    chk("clean_no_err", bus.sb_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ysyx_24090003_regfile_sb.md
YSYX_24090003_REGFILE_SB -- requirements
Module: ysyx_24090003_regfile_sb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data width of every register.
REQ-002 The block SHALL have parameter NREG, default 32, giving the register count; legal values are 16 (RV32E) or 32; AW = log2(NREG).
REQ-003 The block SHALL have parameter BYPASS, default 1, which enables write-to-read forwarding when 1.
REQ-004 cpu_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 cpu_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 rs1_addr, rs2_addr  input  AW each  read addresses.
REQ-007 rs1_data, rs2_data  output  XLEN each  read data.
REQ-008 rs1_busy, rs2_busy  output  1 each  addressed register has a pending write.
REQ-009 iss_valid  input  1  issuing instruction claims destination iss_rd.
REQ-010 iss_rd  input  AW  destination register being claimed.
REQ-011 iss_ready  output  1  claim can be accepted this cycle.
REQ-012 wb_valid  input  1  writeback strobe.
REQ-013 wb_rd  input  AW  writeback register.
REQ-014 wb_data  input  XLEN  writeback value.
REQ-015 flush  input  1  discard all pending claims.
REQ-016 sb_err  output  1  sticky error: writeback to a register that was not busy.

Function
REQ-017 Register 0 SHALL always read 0, SHALL ignore writes, SHALL never be busy, and SHALL always accept a claim that marks nothing.
REQ-018 Reads SHALL be combinational from gpr[rsX_addr], with zero-cycle latency.
REQ-019 When BYPASS=1, wb_valid=1 and wb_rd==rsX_addr!=0, the block SHALL drive rsX_data=wb_data in the same cycle.
REQ-020 When BYPASS=0, rsX_data SHALL return the stored value, and the new value SHALL be visible one cycle after the write edge.
REQ-021 On each rising edge with wb_valid=1 and wb_rd!=0, the block SHALL set gpr[wb_rd] to wb_data; otherwise gpr SHALL hold.
REQ-022 Each register r!=0 SHALL have one busy bit.
REQ-023 The busy bit SHALL set on an edge with iss_valid & iss_ready & iss_rd==r.
REQ-024 The busy bit SHALL clear on an edge with wb_valid & wb_rd==r.
REQ-025 When a set and a clear hit the same register on the same edge, the set SHALL win, so the register stays busy with the new producer.
REQ-026 iss_ready SHALL equal !flush & (iss_rd==0 | !busy[iss_rd] | (wb_valid & wb_rd==iss_rd)), so a write-after-write claim stalls until the older write retires.
REQ-027 When BYPASS=1, rsX_busy SHALL equal busy[rsX_addr] & !(wb_valid & wb_rd==rsX_addr).
REQ-028 When BYPASS=0, rsX_busy SHALL equal busy[rsX_addr].
REQ-029 When flush=1 at an edge, the block SHALL clear all busy bits and accept no claim; a writeback in the same cycle SHALL still update gpr.
REQ-030 A writeback with wb_rd!=0 to a non-busy register SHALL still write gpr and SHALL set sb_err at that edge, unless flush was asserted in the previous cycle (late writebacks after a flush are legal).
REQ-031 sb_err SHALL clear only on reset.
REQ-032 Both read ports SHALL be independent; identical addresses SHALL return identical data and busy values.

Reset
REQ-033 When cpu_rst_n=0, the block SHALL immediately clear all gpr to 0, all busy bits to 0, and sb_err to 0, independent of cpu_clk.
REQ-034 During reset, every output SHALL reflect the cleared state: rsX_data=0, rsX_busy=0, iss_ready=!flush, sb_err=0.
REQ-035 Reset asserted mid-operation SHALL abandon any pending claim, and the first edge after deassertion SHALL behave as from a clean state.

Verification
REQ-036 Reset, then rs1_addr=5 and rs2_addr=0 -> rs1_data=0, rs2_data=0, both busy=0, sb_err=0.
REQ-037 Claim x7, then next cycle wb x7=0xDEADBEEF with rs1_addr=7 -> with BYPASS=1: rs1_data=0xDEADBEEF and rs1_busy=0 in that cycle; with BYPASS=0: rs1_busy=1 that cycle, then data valid and busy=0 the next cycle.
REQ-038 Write x0=0x1234 and claim x0 -> rs1_data(x0)=0, iss_ready=1, no busy bit set.
REQ-039 With x3 busy, assert iss_valid for x3 and no wb -> iss_ready=0, held until wb x3 arrives; the claim is then accepted on the same edge and x3 remains busy.
REQ-040 Claim x4 and x9, then flush with simultaneous wb x4=0x55 -> all busy=0 afterwards, gpr[4]=0x55, sb_err=0; a later wb x9 -> sb_err=1 only if it is not the cycle right after the flush.
REQ-041 Assert cpu_rst_n=0 asynchronously between edges while x2 is busy -> busy and sb_err drop immediately, and gpr[2]=0.
